timer_key_entry: RTL and testbench

Downstream consumer of the keypad function block. Takes validated key codes (1-cycle valid pulse plus 5-bit code), assembles a 4-digit BCD MM:SS entry, and runs a countdown timer from it. The countdown is clocked by the shared 1 kHz pulse. Its outputs feed the FND display driver and the status/alarm logic.

---
 rtl/timer_key_entry_if.sv | 9 +
 rtl/timer_key_entry.sv | 208 ++++++++++++++++++++
 tb/tb_timer_key_entry.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_key_entry_if.sv
// Key strobe bus from the keypad function block into the timer entry logic.
// The code is valid only in the cycle key_valid is high.
interface timer_key_entry_if;
    logic       key_valid;
    logic [4:0] bcd_data;

    modport master (output key_valid, output bcd_data);
    modport slave  (input  key_valid, input  bcd_data);
endinterface

// File: rtl/timer_key_entry.sv
// MM:SS key entry and countdown timer driven by the shared 1 kHz pulse.
// Optional alarm square wave in DONE: define TIMER_ALARM_EN.
//
// state | meaning
// IDLE  | cleared, digits 0000, waiting for a digit
// EDIT  | digits being shifted in, ENTER validates
// RUN   | counting down one second per TICK_DIV pulses
// PAUSE | countdown frozen, sub-second count kept
// DONE  | reached 00:00, alarm active if built in
module timer_key_entry #(
    parameter int TICK_DIV   = 1000,
    parameter int ALARM_HALF = 250
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_pls_1k,
    timer_key_entry_if.slave    key_if,
    output logic [15:0]         o_digits,
    output logic [2:0]          o_state,
    output logic                o_done,
    output logic                o_err,
    output logic                o_alarm
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EDIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [4:0] KEY_ENTER = 5'd10;
    localparam logic [4:0] KEY_CLEAR = 5'd11;
    localparam logic [4:0] KEY_STOP  = 5'd12;
    localparam logic [9:0] TICK_LAST = 10'(TICK_DIV - 1);

    if (TICK_DIV < 2 || TICK_DIV > 1023) begin : g_bad_tick_div
        $error("timer_key_entry: TICK_DIV must be within 2..1023");
    end
    if (ALARM_HALF < 1 || ALARM_HALF > 1024) begin : g_bad_alarm_half
        $error("timer_key_entry: ALARM_HALF must be within 1..1024");
    end

    state_t      state_q, state_d;
    logic [15:0] digits_q, digits_d;
    logic [9:0]  sub_q, sub_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [4:0]  code;
    logic        is_digit, is_enter, is_clear, is_stop;
    logic        entry_ok, step, step_zero;
    logic [15:0] digits_dec;

    // Decrement MM:SS by one second; 00:00 is held, never wrapped.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = v;
        if (v != 16'h0000) begin
            if (s0 != 4'd0) begin
                s0 = s0 - 4'd1;
            end else if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
                s0 = 4'd9;
            end else begin
                s1 = 4'd5;
                s0 = 4'd9;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = 4'd9;
                    m1 = m1 - 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    assign code       = key_if.bcd_data;
    assign is_digit   = key_if.key_valid && (code <= 5'd9);
    assign is_enter   = key_if.key_valid && (code == KEY_ENTER);
    assign is_clear   = key_if.key_valid && (code == KEY_CLEAR);
    assign is_stop    = key_if.key_valid && (code == KEY_STOP);

    assign entry_ok   = (digits_q[7:4] <= 4'd5) && (digits_q != 16'h0000);
    assign step       = (state_q == ST_RUN) && i_pls_1k && (sub_q == TICK_LAST);
    assign digits_dec = bcd_dec(digits_q);
    assign step_zero  = (digits_dec == 16'h0000);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            digits_q <= 16'h0000;
            sub_q    <= 10'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            sub_q    <= sub_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // CLEAR overrides everything, including a coincident second step.
    always_comb begin
        state_d = state_q;
        if (is_clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (is_digit) state_d = ST_EDIT;
                ST_EDIT:  if (is_enter && entry_ok) state_d = ST_RUN;
                ST_RUN: begin
                    if (step && step_zero) begin
                        state_d = ST_DONE;
                    end else if (is_stop) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: if (is_enter) state_d = ST_RUN;
                ST_DONE:  if (is_digit) state_d = ST_EDIT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        digits_d = digits_q;
        sub_d    = sub_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (is_clear) begin
            digits_d = 16'h0000;
            sub_d    = 10'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_digit) digits_d = {digits_q[11:0], code[3:0]};
                end
                ST_EDIT: begin
                    if (is_digit) begin
                        digits_d = {digits_q[11:0], code[3:0]};
                    end else if (is_enter) begin
                        if (entry_ok) begin
                            sub_d = 10'd0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (step) begin
                        sub_d    = 10'd0;
                        digits_d = digits_dec;
                        done_d   = step_zero;
                    end else if (i_pls_1k) begin
                        sub_d = sub_q + 10'd1;
                    end
                end
                ST_DONE: begin
                    if (is_digit) digits_d = {12'h000, code[3:0]};
                end
                default: ;
            endcase
        end
    end

    assign o_digits = digits_q;
    assign o_state  = state_q;
    assign o_done   = done_q;
    assign o_err    = err_q;

`ifdef TIMER_ALARM_EN
    localparam logic [9:0] ALARM_LAST = 10'(ALARM_HALF - 1);

    logic [9:0] alarm_cnt_q;
    logic       alarm_q;

    // Down-counter reloads each half-period; the entry cycle starts high.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            alarm_q     <= 1'b0;
            alarm_cnt_q <= 10'd0;
        end else if (state_d != ST_DONE) begin
            alarm_q     <= 1'b0;
            alarm_cnt_q <= 10'd0;
        end else if (state_q != ST_DONE) begin
            alarm_q     <= 1'b1;
            alarm_cnt_q <= ALARM_LAST;
        end else if (i_pls_1k) begin
            if (alarm_cnt_q == 10'd0) begin
                alarm_q     <= ~alarm_q;
                alarm_cnt_q <= ALARM_LAST;
            end else begin
                alarm_cnt_q <= alarm_cnt_q - 10'd1;
            end
        end
    end

    assign o_alarm = alarm_q;
`else
    assign o_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_timer_key_entry.sv
// Directed bench for timer_key_entry: key table plus countdown corner sequences.
// Alarm expectations follow TIMER_ALARM_EN when the macro is defined.
module tb_timer_key_entry;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EDIT  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pls;
    logic [15:0] digits;
    logic [2:0]  state;
    logic        done;
    logic        err;
    logic        alarm;

    int n_total = 0;
    int n_pass  = 0;
    int done_cnt = 0;
    int d0;

    timer_key_entry_if key_if ();

    timer_key_entry dut (
        .i_clk    (clk),
        .i_rstn   (rstn),
        .i_pls_1k (pls),
        .key_if   (key_if),
        .o_digits (digits),
        .o_state  (state),
        .o_done   (done),
        .o_err    (err),
        .o_alarm  (alarm)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [4:0]  code;
        logic [15:0] digits;
        logic [2:0]  state;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] c);
        key_if.key_valid = 1'b1;
        key_if.bcd_data  = c;
        tick();
        key_if.key_valid = 1'b0;
        key_if.bcd_data  = 5'd0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            pls = 1'b1;
            tick();
            pls = 1'b0;
            tick();
        end
    endtask

    task automatic step_with_key(input logic [4:0] c);
        pls = 1'b1;
        key_if.key_valid = 1'b1;
        key_if.bcd_data  = c;
        tick();
        pls = 1'b0;
        key_if.key_valid = 1'b0;
        key_if.bcd_data  = 5'd0;
    endtask

    task automatic enter_time(input logic [15:0] v);
        press(5'd11);
        press({1'b0, v[15:12]});
        press({1'b0, v[11:8]});
        press({1'b0, v[7:4]});
        press({1'b0, v[3:0]});
        press(5'd10);
    endtask

    task automatic check_ds(input string name, input logic [15:0] ed, input logic [2:0] es);
        check({name, "_digits"}, digits, ed);
        check({name, "_state"}, {13'd0, state}, {13'd0, es});
    endtask

    initial begin
        rstn = 1'b0;
        pls  = 1'b0;
        key_if.key_valid = 1'b0;
        key_if.bcd_data  = 5'd0;

        vecs.push_back('{5'd1,  16'h0001, S_EDIT,  1'b0});
        vecs.push_back('{5'd2,  16'h0012, S_EDIT,  1'b0});
        vecs.push_back('{5'd3,  16'h0123, S_EDIT,  1'b0});
        vecs.push_back('{5'd0,  16'h1230, S_EDIT,  1'b0});
        vecs.push_back('{5'd13, 16'h1230, S_EDIT,  1'b0});
        vecs.push_back('{5'd12, 16'h1230, S_EDIT,  1'b0});
        vecs.push_back('{5'd11, 16'h0000, S_IDLE,  1'b0});
        vecs.push_back('{5'd10, 16'h0000, S_IDLE,  1'b0});
        vecs.push_back('{5'd12, 16'h0000, S_IDLE,  1'b0});
        vecs.push_back('{5'd0,  16'h0000, S_EDIT,  1'b0});
        vecs.push_back('{5'd10, 16'h0000, S_EDIT,  1'b1});
        vecs.push_back('{5'd0,  16'h0000, S_EDIT,  1'b0});
        vecs.push_back('{5'd7,  16'h0007, S_EDIT,  1'b0});
        vecs.push_back('{5'd5,  16'h0075, S_EDIT,  1'b0});
        vecs.push_back('{5'd10, 16'h0075, S_EDIT,  1'b1});
        vecs.push_back('{5'd5,  16'h0755, S_EDIT,  1'b0});
        vecs.push_back('{5'd9,  16'h7559, S_EDIT,  1'b0});
        vecs.push_back('{5'd31, 16'h7559, S_EDIT,  1'b0});
        vecs.push_back('{5'd10, 16'h7559, S_RUN,   1'b0});
        vecs.push_back('{5'd10, 16'h7559, S_RUN,   1'b0});
        vecs.push_back('{5'd1,  16'h7559, S_RUN,   1'b0});
        vecs.push_back('{5'd12, 16'h7559, S_PAUSE, 1'b0});
        vecs.push_back('{5'd3,  16'h7559, S_PAUSE, 1'b0});
        vecs.push_back('{5'd12, 16'h7559, S_PAUSE, 1'b0});
        vecs.push_back('{5'd10, 16'h7559, S_RUN,   1'b0});
        vecs.push_back('{5'd11, 16'h0000, S_IDLE,  1'b0});

        tick();
        tick();
        check_ds("reset", 16'h0000, S_IDLE);
        check("reset_done", {15'd0, done}, 16'd0);
        check("reset_err", {15'd0, err}, 16'd0);
        check("reset_alarm", {15'd0, alarm}, 16'd0);
        rstn = 1'b1;
        tick();

        foreach (vecs[i]) begin
            press(vecs[i].code);
            check_ds($sformatf("vec%0d", i), vecs[i].digits, vecs[i].state);
            check($sformatf("vec%0d_err", i), {15'd0, err}, {15'd0, vecs[i].err});
        end

        // basic countdown 12:30 -> 12:29
        enter_time(16'h1230);
        check_ds("run1230", 16'h1230, S_RUN);
        pulses(999);
        check_ds("pre_step", 16'h1230, S_RUN);
        pulses(1);
        check_ds("step1229", 16'h1229, S_RUN);

        // minute borrow
        enter_time(16'h0100);
        pulses(1000);
        check_ds("borrow0059", 16'h0059, S_RUN);
        enter_time(16'h1000);
        pulses(1000);
        check_ds("borrow0959", 16'h0959, S_RUN);

        // reach 00:00, single done pulse, then hold
        enter_time(16'h0002);
        d0 = done_cnt;
        pulses(1000);
        check_ds("run0001", 16'h0001, S_RUN);
        pulses(999);
        pls = 1'b1;
        tick();
        pls = 1'b0;
        check_ds("done_entry", 16'h0000, S_DONE);
        check("done_pulse", {15'd0, done}, 16'd1);
        check("done_no_err", {15'd0, err}, 16'd0);
        tick();
        check("done_pulse_end", {15'd0, done}, 16'd0);
        pulses(3000);
        check_ds("done_hold", 16'h0000, S_DONE);
        check("done_count", 16'(done_cnt - d0), 16'd1);

        // pause keeps the sub-second count
        enter_time(16'h0010);
        pulses(400);
        press(5'd12);
        check_ds("pause", 16'h0010, S_PAUSE);
        pulses(500);
        check_ds("pause_hold", 16'h0010, S_PAUSE);
        press(5'd10);
        check_ds("resume", 16'h0010, S_RUN);
        pulses(599);
        check_ds("resume_pre", 16'h0010, S_RUN);
        pulses(1);
        check_ds("resume_step", 16'h0009, S_RUN);

        // CLEAR coincident with a step
        pulses(999);
        step_with_key(5'd11);
        check_ds("clear_step", 16'h0000, S_IDLE);
        check("clear_step_done", {15'd0, done}, 16'd0);

        // STOP coincident with a step, then digit coincident with a step
        enter_time(16'h0010);
        pulses(999);
        step_with_key(5'd12);
        check_ds("stop_step", 16'h0009, S_PAUSE);
        press(5'd10);
        pulses(999);
        step_with_key(5'd5);
        check_ds("digit_step", 16'h0008, S_RUN);

        // STOP coincident with the final step: DONE wins
        enter_time(16'h0001);
        pulses(999);
        step_with_key(5'd12);
        check_ds("stop_final", 16'h0000, S_DONE);
        check("stop_final_done", {15'd0, done}, 16'd1);
`ifdef TIMER_ALARM_EN
        check("alarm_entry", {15'd0, alarm}, 16'd1);
        pulses(249);
        check("alarm_hi_end", {15'd0, alarm}, 16'd1);
        pulses(1);
        check("alarm_lo", {15'd0, alarm}, 16'd0);
        pulses(249);
        check("alarm_lo_end", {15'd0, alarm}, 16'd0);
        pulses(1);
        check("alarm_hi2", {15'd0, alarm}, 16'd1);
`else
        check("alarm_entry", {15'd0, alarm}, 16'd0);
        pulses(250);
        check("alarm_off", {15'd0, alarm}, 16'd0);
`endif
        press(5'd7);
        check_ds("done_digit", 16'h0007, S_EDIT);
        check("alarm_leave", {15'd0, alarm}, 16'd0);

        // reset aborts a countdown on the final pulse
        enter_time(16'h0001);
        pulses(999);
        d0 = done_cnt;
        rstn = 1'b0;
        pls = 1'b1;
        tick();
        pls = 1'b0;
        check_ds("rst_abort", 16'h0000, S_IDLE);
        check("rst_abort_done", {15'd0, done}, 16'd0);
        tick();
        rstn = 1'b1;
        tick();
        check("rst_no_done", 16'(done_cnt - d0), 16'd0);
        press(5'd4);
        check_ds("after_rst", 16'h0004, S_EDIT);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
